// File: rtl/cb_filter_arb.sv
// cb_filter_arb: front-end arbiter and sequencer for one cb_filter instance.
//
// Shares the filter's single increment port and single decrement port between
// NumReq requesters. Each port has its own round-robin arbiter. Inserts are
// blocked while the filter reports full. The block also runs the filter clear
// sequence on request and keeps a sticky error flag.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   incr_valid_i/data_i/ready_o    insert requesters (valid/ready, zero latency)
//   decr_valid_i/data_i/ready_o    remove requesters (valid/ready, zero latency)
//   clear_req_i / clear_ack_o      clear request (level) / completion pulse
//   error_o                        sticky filter error, cleared by a clear
//   flt_incr_*_o, flt_decr_*_o     to the filter's increment/decrement ports
//   flt_clear_o                    to the filter's clear input
//   flt_full_i/empty_i/error_i     status from the filter
module cb_filter_arb #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 11
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  incr_valid_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   incr_data_i,
    output logic [NumReq-1:0]                  incr_ready_o,
    input  logic [NumReq-1:0]                  decr_valid_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   decr_data_i,
    output logic [NumReq-1:0]                  decr_ready_o,
    input  logic                               clear_req_i,
    output logic                               clear_ack_o,
    output logic                               error_o,
    output logic [DataWidth-1:0]               flt_incr_data_o,
    output logic                               flt_incr_valid_o,
    output logic [DataWidth-1:0]               flt_decr_data_o,
    output logic                               flt_decr_valid_o,
    output logic                               flt_clear_o,
    input  logic                               flt_full_i,
    input  logic                               flt_empty_i,
    input  logic                               flt_error_i
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {RUN, CLR, CHK, ACK} state_e;

    typedef struct packed {
        logic            hit;
        logic [PtrW-1:0] idx;
    } pick_t;

    // First requesting index at or after ptr, wrapping around.
    function automatic pick_t rr_pick(input logic [NumReq-1:0] req,
                                      input logic [PtrW-1:0]   ptr);
        pick_t           p;
        int              j;
        logic [PtrW-1:0] jj;
        p.hit = 1'b0;
        p.idx = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            j  = (int'(ptr) + k) % int'(NumReq);
            jj = PtrW'(j);
            if (!p.hit && req[jj]) begin
                p.hit = 1'b1;
                p.idx = jj;
            end
        end
        return p;
    endfunction

    // Priority moves to the index after the one just granted.
    function automatic logic [PtrW-1:0] rr_next(input logic [PtrW-1:0] idx);
        return (idx == PtrW'(NumReq - 1)) ? '0 : idx + 1'b1;
    endfunction

    state_e          state_q;
    logic            clear_q;
    logic            ack_q;
    logic            error_q;
    logic [PtrW-1:0] incr_ptr_q;
    logic [PtrW-1:0] decr_ptr_q;

    pick_t           incr_pick;
    pick_t           decr_pick;
    logic            grant_ok;
    logic            incr_gnt;
    logic            decr_gnt;

    // Grant path: purely combinational so the handshake cycle is the cycle
    // the filter counts the item. rst_ni is included so that ready and the
    // forwarded valids read 0 for as long as reset is held, even with
    // requesters still presenting valid.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        incr_ready_o     = '0;
        decr_ready_o     = '0;
        flt_incr_valid_o = 1'b0;
        flt_incr_data_o  = '0;
        flt_decr_valid_o = 1'b0;
        flt_decr_data_o  = '0;

        incr_pick = rr_pick(incr_valid_i, incr_ptr_q);
        decr_pick = rr_pick(decr_valid_i, decr_ptr_q);

        // A clear request blocks grants in the very cycle it is seen.
        grant_ok = rst_ni && (state_q == RUN) && !clear_req_i;
        incr_gnt = grant_ok && !flt_full_i && incr_pick.hit;
        decr_gnt = grant_ok && decr_pick.hit;

        if (incr_gnt) begin
            incr_ready_o[incr_pick.idx] = 1'b1;
            flt_incr_valid_o            = 1'b1;
            flt_incr_data_o             = incr_data_i[incr_pick.idx];
        end
        if (decr_gnt) begin
            decr_ready_o[decr_pick.idx] = 1'b1;
            flt_decr_valid_o            = 1'b1;
            flt_decr_data_o             = decr_data_i[decr_pick.idx];
        end
    end

    // Round-robin pointers advance only on a grant of their own port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            incr_ptr_q <= '0;
            decr_ptr_q <= '0;
        end else begin
            if (incr_gnt) incr_ptr_q <= rr_next(incr_pick.idx);
            if (decr_gnt) decr_ptr_q <= rr_next(decr_pick.idx);
        end
    end

    // Clear sequencer and sticky error. clear/ack outputs are registered
    // alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            clear_q <= 1'b0;
            ack_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (flt_error_i) error_q <= 1'b1;
            case (state_q)
                RUN: begin
                    if (clear_req_i) begin
                        state_q <= CLR;
                        clear_q <= 1'b1;
                    end
                end
                CLR: begin
                    state_q <= CHK;
                    clear_q <= 1'b0;
                end
                CHK: begin
                    // The filter must report empty after a clear; otherwise
                    // re-issue it, with no retry limit.
                    if (flt_empty_i) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= CLR;
                        clear_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= RUN;
                    ack_q   <= 1'b0;
                    // Overrides the set above: a clear beats a concurrent error.
                    error_q <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    clear_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign flt_clear_o = clear_q;
    assign clear_ack_o = ack_q;
    assign error_o     = error_q;

endmodule

// File: doc/cb_filter_arb.md
# cb_filter_arb

Front-end arbiter and sequencer for one `cb_filter` instance. It shares the filter's single increment port and single decrement port between `NumReq` independent requesters over valid/ready handshakes, and blocks inserts while the filter reports full. It also runs the clear sequence on request and keeps a sticky error flag. The block sits between the requesting units (e.g. transaction trackers) and the filter; the lookup port is not routed through it.

## Interface
- `NumReq`, default 2: number of insert requesters and number of remove requesters (>= 1).
- `DataWidth`, default 11: width of data items; must equal the filter's `InpWidth`.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: asynchronous reset, active low.
- `incr_valid_i`  in  NumReq: insert request valid, one bit per requester.
- `incr_data_i`  in  NumReq x DataWidth: insert item, one per requester.
- `incr_ready_o`  out  NumReq: insert accepted this cycle.
- `decr_valid_i`  in  NumReq: remove request valid.
- `decr_data_i`  in  NumReq x DataWidth: remove item.
- `decr_ready_o`  out  NumReq: remove accepted this cycle.
- `clear_req_i`  in  1: request to clear the filter; level, held until ack.
- `clear_ack_o`  out  1: one-cycle pulse when the clear has completed.
- `error_o`  out  1: sticky filter error.
- `flt_incr_data_o`  out  DataWidth: to filter `incr_data_i`.
- `flt_incr_valid_o`  out  1: to filter `incr_valid_i`.
- `flt_decr_data_o`  out  DataWidth: to filter `decr_data_i`.
- `flt_decr_valid_o`  out  1: to filter `decr_valid_i`.
- `flt_clear_o`  out  1: to filter `filter_clear_i`.
- `flt_full_i`  in  1: from filter `filter_full_o`.
- `flt_empty_i`  in  1: from filter `filter_empty_o`.
- `flt_error_i`  in  1: from filter `filter_error_o`.

## Operation
- FSM states: RUN, CLR, CHK, ACK. Reset state is RUN.
- **RUN, insert path:** round-robin arbitration over `incr_valid_i`. Priority starts at the index after the last granted one.
  - With no grant since reset, index 0 has highest priority.
  - A grant is given only if `flt_full_i`=0 and `clear_req_i`=0.
  - The granted requester sees `incr_ready_o[i]`=1 and is the only bit set.
  - `flt_incr_valid_o`=1 and `flt_incr_data_o` = that requester's data.
  - The insert pointer advances only on a grant.
- **RUN, remove path:** an independent round-robin over `decr_valid_i` with its own pointer. Same rules, except removes ignore `flt_full_i` and are still gated by `clear_req_i`.
- **Simultaneous events:** one insert and one remove may both be granted in the same cycle, including with identical data. Both are forwarded; the filter nets them.
- When no grant is given, `flt_*_valid_o`=0 and `flt_*_data_o`='0 (no data leakage).
- **Clear sequence:**
  - RUN and `clear_req_i`=1 -> CLR. No grant is given in the cycle `clear_req_i` is seen.
  - CLR: `flt_clear_o`=1 for exactly one cycle -> CHK.
  - CHK: sample `flt_empty_i`. If 1 -> ACK. If 0 -> CLR, re-issuing the clear; the retry count is unbounded.
  - ACK: `clear_ack_o`=1 for one cycle, then `error_o` is cleared -> RUN.
  - The requester deasserts `clear_req_i` the cycle after the ack. If it is still high in RUN, a new clear starts.
- No grants are given in CLR, CHK or ACK; all ready outputs are 0.
- **Error:** `error_o` is set on any cycle with `flt_error_i`=1 and held until the ACK state. If `flt_error_i` and ACK occur in the same cycle, clear wins.
- **Handshake rule:** a requester must keep valid and data stable until ready. `incr_ready_o`/`decr_ready_o` may depend combinationally on `incr_valid_i`/`decr_valid_i`; valid must never depend on ready.

## Timing
- Request to filter: zero latency. The handshake cycle is the cycle the filter counts the item (filter updates on the following edge).
- `flt_full_i` is used as-is in the cycle it is seen. If an insert is granted while the filter is at its last free slot, that insert is accepted. Full takes effect from the next cycle.
- Clear: `clear_req_i` rises in cycle t -> `flt_clear_o` in t+1 -> CHK in t+2 -> `clear_ack_o` in t+3 (best case).
- **Reset values:**
  - Data outputs: `'0`.
  - Valid, ready, clear, ack and error outputs: 0.
  - Both round-robin pointers: 0.
  - State: RUN.
- Reset asserted mid-sequence returns the block to RUN immediately. A `flt_clear_o` pulse in progress is dropped.

## Test plan
- **Fairness:** `NumReq`=2, both `incr_valid_i`=1 continuously with data 5 and 9 -> `flt_incr_data_o` alternates 5, 9, 5, 9. `incr_ready_o` alternates 01, 10, 01, 10 (bit 0 = requester 0).
- **Full gating:** `flt_full_i`=1 with `incr_valid_i`=01 and `decr_valid_i`=10 (data 7) -> `incr_ready_o`=00, `flt_incr_valid_o`=0, `decr_ready_o`=10, `flt_decr_data_o`=7.
- **Simultaneous ops:** insert 3 and remove 3 in the same cycle -> both valids 1 and both data 3 in that cycle.
- **Clear:** hold `clear_req_i` with `flt_empty_i`=1 -> `flt_clear_o` one cycle later, `clear_ack_o` 3 cycles after the request. All readies stay 0 throughout.
- **Clear retry:** `flt_empty_i`=0 in the first CHK and 1 in the second -> two `flt_clear_o` pulses, then a single ack.
- **Error and mid-clear reset:**
  - Pulse `flt_error_i` -> `error_o` stays 1 through the clear and drops after ACK.
  - Assert `rst_ni`=0 during CLR -> all outputs return to reset values asynchronously.
